// File: rtl/bin_ker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bin_ker_pkg
// Brief    : Shared constants and state encoding for the binary kernel streamer.
// Revision : 1.0 - initial release
// ============================================================================
package bin_ker_pkg;

  localparam int KSIZE    = 3;
  localparam int RESULT_W = 4;
  localparam int WIN_BITS = KSIZE * KSIZE;

  // LSB of each window row triple; within a triple bit 0 is the newest column
  localparam int ROW_TOP_LSB = 2 * KSIZE;
  localparam int ROW_MID_LSB = KSIZE;
  localparam int ROW_BOT_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bin_win_count.sv
`default_nettype none
// ============================================================================
// Module   : bin_win_count
// Brief    : Combinational popcount of (window AND kernel) over a 3x3 window.
// Revision : 1.0 - initial release
// ============================================================================
module bin_win_count
  import bin_ker_pkg::*;
(
  input  logic [WIN_BITS-1:0] win_i,
  input  logic [WIN_BITS-1:0] kernel_i,
  output logic [RESULT_W-1:0] count_o
);

  logic [WIN_BITS-1:0] w_and;

  always_comb begin
    w_and   = win_i & kernel_i;
    count_o = '0;
    for (int i = 0; i < WIN_BITS; i++) begin
      count_o = count_o + {{(RESULT_W-1){1'b0}}, w_and[i]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/bin_ker_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bin_ker_ctrl
// Brief    : Streams a latched 3x3 binary kernel over a raster 1-bit frame and
//            emits per-window match counts. `BIN_KER_CTRL_THRESH_EN adds a
//            threshold input and a hit flag.
// Revision : 1.0 - initial release
// ============================================================================
module bin_ker_ctrl
  import bin_ker_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIN_BITS-1:0] kernel,
`ifdef BIN_KER_CTRL_THRESH_EN
  input  logic [RESULT_W-1:0] thresh,
  output logic                out_hit,
`endif
  output logic                busy,
  input  logic                in_valid,
  input  logic                in_pixel,
  output logic                in_ready,
  output logic                out_valid,
  output logic [RESULT_W-1:0] out_result,
  output logic                out_last,
  input  logic                out_ready,
  output logic                done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_t              state_q;
  logic [WIN_BITS-1:0] kernel_q;
  logic [WIN_BITS-1:0] win_q;
  logic [WIN_BITS-1:0] win_d;
  logic [IMG_W-1:0]    lb0_q;
  logic [IMG_W-1:0]    lb1_q;
  logic [COL_W-1:0]    col_q;
  logic [COL_W-1:0]    col_d;
  logic [ROW_W-1:0]    row_q;
  logic [ROW_W-1:0]    row_d;
  logic                busy_q;
  logic                done_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic [RESULT_W-1:0] out_result_q;

  logic [RESULT_W-1:0] w_count;
  logic                w_pix_acc;
  logic                w_last_pix;
  logic                w_emit;
  logic                w_out_hs;
  logic                w_unused;

  assign in_ready   = (state_q == RUN) & (~out_valid_q | out_ready);
  assign w_pix_acc  = in_valid & in_ready;
  assign w_out_hs   = out_valid_q & out_ready;
  assign w_last_pix = (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1));
  assign w_emit     = w_pix_acc && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // Line buffer taps give the same column one and two rows above the new pixel
  assign win_d = {win_q[ROW_TOP_LSB +: KSIZE-1], lb1_q[IMG_W-1],
                  win_q[ROW_MID_LSB +: KSIZE-1], lb0_q[IMG_W-1],
                  win_q[ROW_BOT_LSB +: KSIZE-1], in_pixel};

  assign w_unused = ^{win_q[ROW_TOP_LSB+KSIZE-1], win_q[ROW_MID_LSB+KSIZE-1],
                      win_q[ROW_BOT_LSB+KSIZE-1]};

  always_comb begin
    col_d = col_q + COL_W'(1);
    row_d = row_q;
    if (col_q == COL_W'(IMG_W - 1)) begin
      col_d = '0;
      row_d = row_q + ROW_W'(1);
    end
  end

  bin_win_count u_count (
    .win_i    (win_d),
    .kernel_i (kernel_q),
    .count_o  (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      kernel_q <= '0;
      lb0_q    <= '0;
      lb1_q    <= '0;
      win_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            kernel_q <= kernel;
            col_q    <= '0;
            row_q    <= '0;
          end
        end
        RUN: begin
          if (w_pix_acc) begin
            lb0_q <= {lb0_q[IMG_W-2:0], in_pixel};
            lb1_q <= {lb1_q[IMG_W-2:0], lb0_q[IMG_W-1]};
            win_q <= win_d;
            col_q <= col_d;
            row_q <= row_d;
            if (w_last_pix) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_out_hs && out_last_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Single-entry output stage: a new result may replace one handshaking now
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_result_q <= '0;
    end else if (w_emit) begin
      out_valid_q  <= 1'b1;
      out_last_q   <= w_last_pix;
      out_result_q <= w_count;
    end else if (w_out_hs) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

`ifdef BIN_KER_CTRL_THRESH_EN
  logic [RESULT_W-1:0] thresh_q;
  logic                out_hit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thresh_q  <= '0;
      out_hit_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start) begin
        thresh_q <= thresh;
      end
      if (w_emit) begin
        out_hit_q <= (w_count >= thresh_q);
      end
    end
  end

  assign out_hit = out_hit_q;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_result = out_result_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_ker_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_ker_ctrl
// Brief    : Self-checking bench for bin_ker_ctrl on a 4x4 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_ker_ctrl;

  localparam int         IW   = 4;
  localparam int         IH   = 4;
  localparam int         NRES = (IW - 2) * (IH - 2);
  localparam logic [3:0] THR  = 4'd5;

  typedef struct packed {
    logic [3:0] res;
    logic       last;
    logic       hit;
  } exp_t;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       start     = 1'b0;
  logic [8:0] kernel    = '0;
  logic       in_valid  = 1'b0;
  logic       in_pixel  = 1'b0;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_result;
  logic       out_last;
  logic       done;
`ifdef BIN_KER_CTRL_THRESH_EN
  logic [3:0] thresh = THR;
  logic       out_hit;
`endif

  int   tests = 0;
  int   fails = 0;
  bit   drv_timeout;
  exp_t exp_q[$];

  bin_ker_ctrl #(.IMG_W(IW), .IMG_H(IH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .kernel     (kernel),
`ifdef BIN_KER_CTRL_THRESH_EN
    .thresh     (thresh),
    .out_hit    (out_hit),
`endif
    .busy       (busy),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference: window bit (2-dr)*3 + (2-dc) holds pixel (r-2+dr, c-2+dc)
  function automatic logic [3:0] model(input logic [15:0] img, input logic [8:0] k,
                                       input int r, input int c);
    logic [8:0] w;
    logic [3:0] n;
    w = '0;
    n = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[(2-dr)*3 + (2-dc)] = img[(r-2+dr)*IW + (c-2+dc)];
    for (int b = 0; b < 9; b++) n = n + {3'b000, w[b] & k[b]};
    return n;
  endfunction

  task automatic send_frame(input logic [15:0] img, input logic [8:0] kern, input int npix);
    int   guard;
    bit   acc;
    int   r;
    int   c;
    exp_t e;
    @(posedge clk); #1;
    start  = 1'b1;
    kernel = kern;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < npix; i++) begin
      r        = i / IW;
      c        = i % IW;
      in_valid = 1'b1;
      in_pixel = img[i];
      if (r >= 2 && c >= 2) begin
        e.res  = model(img, kern, r, c);
        e.last = (i == IW*IH - 1);
        e.hit  = (e.res >= THR);
        exp_q.push_back(e);
      end
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 64) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) drv_timeout = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b want 0", busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset in_ready got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    tests++; if (out_result !== 4'd0) begin fails++; $display("FAIL reset out_result got %0d want 0", out_result); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset out_last got %b want 0", out_last); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset done got %b want 0", done); end
`ifdef BIN_KER_CTRL_THRESH_EN
    tests++; if (out_hit !== 1'b0) begin fails++; $display("FAIL reset out_hit got %b want 0", out_hit); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle busy got %b want 0", busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL idle in_ready got %b want 0", in_ready); end
  endtask

  task automatic test_frame(input string name, input logic [15:0] img, input logic [8:0] kern);
    int   got;
    int   guard;
    exp_t e;
    out_ready   = 1'b1;
    drv_timeout = 1'b0;
    got         = 0;
    fork
      send_frame(img, kern, IW*IH);
      begin
        guard = 0;
        while (got < NRES && guard < 300) begin
          @(negedge clk);
          guard++;
          if (out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++; $display("FAIL %s extra result got %0d want none", name, out_result);
            end else begin
              e = exp_q.pop_front();
              if (out_result !== e.res) begin
                fails++; $display("FAIL %s result%0d got %0d want %0d", name, got, out_result, e.res);
              end
              tests++;
              if (out_last !== e.last) begin
                fails++; $display("FAIL %s last%0d got %b want %b", name, got, out_last, e.last);
              end
`ifdef BIN_KER_CTRL_THRESH_EN
              tests++;
              if (out_hit !== e.hit) begin
                fails++; $display("FAIL %s hit%0d got %b want %b", name, got, out_hit, e.hit);
              end
`endif
              tests++;
              if (busy !== 1'b1) begin fails++; $display("FAIL %s busy_run got %b want 1", name, busy); end
            end
            got++;
          end
        end
      end
    join
    tests++; if (drv_timeout) begin fails++; $display("FAIL %s input_stall got timeout want accept", name); end
    tests++; if (got != NRES) begin fails++; $display("FAIL %s count got %0d want %0d", name, got, NRES); end
    @(negedge clk);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL %s done got %b want 1", name, done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s busy_end got %b want 0", name, busy); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL %s done_pulse got %b want 0", name, done); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL %s idle_valid got %b want 0", name, out_valid); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL %s leftover got %0d want 0", name, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int         got;
    int         guard;
    bit         seen;
    logic [3:0] held;
    exp_t       e;
    out_ready   = 1'b0;
    drv_timeout = 1'b0;
    got         = 0;
    fork
      send_frame(16'hB5A3, 9'h1FF, IW*IH);
      begin
        seen  = 1'b0;
        guard = 0;
        while (!seen && guard < 300) begin
          @(negedge clk);
          guard++;
          seen = out_valid;
        end
        tests++; if (!seen) begin fails++; $display("FAIL bp first_valid got 0 want 1"); end
        held = out_result;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          start  = (k == 0);
          kernel = '0;
          @(negedge clk);
          tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp hold_valid got %b want 1", out_valid); end
          tests++; if (out_result !== held) begin fails++; $display("FAIL bp hold_result got %0d want %0d", out_result, held); end
          tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp in_ready got %b want 0", in_ready); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        guard = 0;
        while (got < NRES && guard < 300) begin
          @(negedge clk);
          guard++;
          if (out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++; $display("FAIL bp extra result got %0d want none", out_result);
            end else begin
              e = exp_q.pop_front();
              if (out_result !== e.res) begin
                fails++; $display("FAIL bp result%0d got %0d want %0d", got, out_result, e.res);
              end
              tests++;
              if (out_last !== e.last) begin
                fails++; $display("FAIL bp last%0d got %b want %b", got, out_last, e.last);
              end
            end
            got++;
          end
        end
      end
    join
    tests++; if (drv_timeout) begin fails++; $display("FAIL bp input_stall got timeout want accept"); end
    tests++; if (got != NRES) begin fails++; $display("FAIL bp count got %0d want %0d", got, NRES); end
    @(negedge clk);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL bp done got %b want 1", done); end
    @(negedge clk);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL bp leftover got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    out_ready   = 1'b1;
    drv_timeout = 1'b0;
    send_frame(16'h3C96, 9'h0F3, 7);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid busy_before got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid busy got %b want 0", busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid in_ready got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid out_valid got %b want 0", out_valid); end
    tests++; if (out_result !== 4'd0) begin fails++; $display("FAIL mid out_result got %0d want 0", out_result); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL mid out_last got %b want 0", out_last); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL mid done got %b want 0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    test_frame("after_reset", 16'h3C96, 9'h0F3);
  endtask

  initial begin
    test_reset();
    test_frame("all_ones", 16'hFFFF, 9'h1FF);
    test_frame("kernel_zero", 16'hFFFF, 9'h000);
    // pixel = 1 where (row + col) is even
    test_frame("checkerboard", 16'hA5A5, 9'b101010101);
    test_backpressure();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/bin_ker_ctrl.md
Name: bin_ker_ctrl

Overview:
Streaming controller that sequences a 3x3 binary kernel over a raster-scanned 1-bit image frame. Holds two line buffers and a 3x3 window and latches the kernel at frame start. Each full window produces a 4-bit match count (popcount of window AND kernel, 0..9). Sits between the binary pixel source and downstream feature logic, with valid/ready on both sides.

Parameters:
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in rows (>=3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  frame start pulse; honoured only in IDLE
kernel  in  9  kernel bits, sampled on accepted start
busy  out  1  high from accepted start until done pulse
in_valid  in  1  pixel valid
in_pixel  in  1  binary pixel, raster order (row-major, left to right)
in_ready  out  1  pixel accepted when in_valid & in_ready
out_valid  out  1  result valid
out_result  out  4  match count 0..9
out_last  out  1  marks final result of frame
out_ready  in  1  downstream accepts when out_valid & out_ready
done  out  1  one-cycle pulse, frame complete

Behaviour:
- Reset (async, any time including mid-frame): state=IDLE; busy, in_ready, out_valid, out_last, done=0; out_result=0; row/col counters=0; line buffers, window, kernel register cleared. No partial frame resumes.
- States: IDLE -> RUN on start (kernel latched, counters cleared). RUN -> DRAIN when last pixel (row IMG_H-1, col IMG_W-1) is accepted. DRAIN -> IDLE when final result handshakes; done pulses that same transition cycle+1 (registered), busy drops with done.
- start during RUN/DRAIN ignored.
- in_ready = (state==RUN) & (!out_valid | out_ready). Per accepted pixel: shift window, push pixel into line buffer 0, line buffer 0 output into line buffer 1, advance col; col wraps IMG_W-1 -> 0 and increments row.
- Window bit order: w[8:6] = row r-2, w[5:3] = row r-1, w[2:0] = row r; within each triple bit 2 = col c-2, bit 0 = col c. kernel uses the same mapping.
- Result generated when accepted pixel has row>=2 and col>=2; windows never straddle rows (no padding). Results per frame = (IMG_W-2)*(IMG_H-2).
- Latency: out_valid rises cycle after the completing pixel handshake; out_result = popcount(w & kernel_q) computed in 4 bits, no overflow possible (max 9).
- Output register single-entry: holds value/out_last stable while out_valid & !out_ready. Simultaneous output handshake and new result loads new value same cycle (no bubble).
- Pixels completing no window (row<2 or col<2) accepted without touching the output register.
- out_last set with result from last pixel; cleared on its handshake.

Optional Feature:
BIN_KER_CTRL_THRESH_EN: adds input thresh[3:0] (sampled with kernel at start) and output out_hit (1 bit, valid with out_valid) = (match count >= thresh). Without macro: ports absent, no threshold logic.

Decomposition:
- Package bin_ker_pkg: KSIZE=3, RESULT_W=4, state enum (IDLE, RUN, DRAIN), window bit-index constants.
- Sub-module bin_win_count: combinational 9-bit window & kernel -> 4-bit popcount; instantiated once.

Test Plan:
- IMG_W=IMG_H=4, kernel=9'h1FF, all-ones image, out_ready=1 -> 4 results of 9, out_last on 4th, done one pulse, busy low after.
- Same frame, kernel=0 -> 4 results of 0; same count/order/last/done timing.
- 4x4 checkerboard (pixel=1 when (r+c) even), kernel=9'b101010101 -> results 5,0,0,5 in order.
- 4x4 frame, out_ready low 3 cycles on first result -> out_result/out_valid held, in_ready low, no results lost or duplicated.
- Assert rst mid-frame after 7 pixels -> all outputs 0 same cycle, busy=0; new start then completes a normal frame with correct results.
- BIN_KER_CTRL_THRESH_EN, thresh=5, checkerboard case -> out_hit 1,0,0,1.
